// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//   A WIDTH-bit, DEPTH-stage stallable delay line. Each stage has a valid flag.
//   There is a synchronous flush of the flags, and a registered count of how
//   many stages currently hold valid data.
//
//   Priority at each rising edge: rst_sync > clr > en > hold.
//   Data always shifts when en=1, clr or not. Only the valid flags are flushed.
//   Consumers must qualify taps with valid_taps.
//
// Ports
//   clk         rising-edge clock
//   rst_sync    synchronous active-high reset (data <- RESET_VAL, flags <- 0)
//   en          advance enable; 0 = every stage holds
//   clr         synchronous flush of all valid flags (and occupancy)
//   d, d_valid  input word and its qualifier, entering stage 0
//   q, q_valid  last stage (DEPTH-1) data and flag
//   taps        all stage data, stage i at [i*WIDTH +: WIDTH]
//   valid_taps  bit i = valid flag of stage i
//   occupancy   number of set valid flags, kept as a register
// -----------------------------------------------------------------------------
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_sync,
  input  logic                       en,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [WIDTH*DEPTH-1:0]     taps,
  output logic [DEPTH-1:0]           valid_taps,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            r_vld;
  logic [OCC_W-1:0]            r_occ;

  // Next-state values for a plain advance. They are only used when en=1.
  logic [DEPTH-1:0][WIDTH-1:0] w_data_sh;
  logic [DEPTH-1:0]            w_vld_sh;
  logic [OCC_W-1:0]            w_occ_adv;

  assign w_data_sh[0] = d;
  assign w_vld_sh[0]  = d_valid;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign w_data_sh[gi] = r_data[gi-1];
      assign w_vld_sh[gi]  = r_vld[gi-1];
    end
  endgenerate

  // Entry and exit in the same cycle cancel out. The count cannot leave
  // 0..DEPTH because it is tied one-to-one to the flags.
  assign w_occ_adv = r_occ + OCC_W'(d_valid) - OCC_W'(r_vld[DEPTH-1]);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_data <= {DEPTH{RESET_VAL}};
      r_vld  <= '0;
      r_occ  <= '0;
    end else begin
      // Data ignores clr. It only follows en.
      if (en) r_data <= w_data_sh;

      if (clr) begin
        r_vld <= '0;
        r_occ <= '0;
      end else if (en) begin
        r_vld <= w_vld_sh;
        r_occ <= w_occ_adv;
      end
    end
  end

  assign q          = r_data[DEPTH-1];
  assign q_valid    = r_vld[DEPTH-1];
  assign taps       = r_data;
  assign valid_taps = r_vld;
  assign occupancy  = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_sync = 1'b1;
  logic       en = 1'b0, clr = 1'b0, d_valid = 1'b0;
  logic [7:0] d = 8'h00;

  // DEPTH=4 instance
  logic [7:0]  q4;
  logic        qv4;
  logic [31:0] taps4;
  logic [3:0]  vt4;
  logic [2:0]  occ4;
  // DEPTH=1 instance, driven in parallel
  logic [7:0]  q1;
  logic        qv1;
  logic [7:0]  taps1;
  logic [0:0]  vt1;
  logic [0:0]  occ1;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u4 (
    .clk(clk), .rst_sync(rst_sync), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q4), .q_valid(qv4), .taps(taps4), .valid_taps(vt4), .occupancy(occ4));

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) u1 (
    .clk(clk), .rst_sync(rst_sync), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .taps(taps1), .valid_taps(vt1), .occupancy(occ1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each valid word is pushed with the enabled-edge index it
  // entered on. It sits on q exactly DEPTH-1 enabled edges later.
  typedef struct { logic [7:0] d; int k; } ent_t;
  ent_t sb4[$];
  ent_t sb1[$];
  int   en_cnt = 0;

  task automatic step(input logic r, input logic e, input logic c,
                      input logic [7:0] dd, input logic dv);
    logic exp_qv;
    @(negedge clk);
    rst_sync = r; en = e; clr = c; d = dd; d_valid = dv;
    @(posedge clk);
    #1;
    if (r) begin
      sb4.delete(); sb1.delete();
    end else begin
      if (e) en_cnt++;
      if (c) begin
        sb4.delete(); sb1.delete();
      end else if (e && dv) begin
        sb4.push_back('{dd, en_cnt});
        sb1.push_back('{dd, en_cnt});
      end
      while (sb4.size() > 0 && en_cnt - sb4[0].k >= 4) void'(sb4.pop_front());
      while (sb1.size() > 0 && en_cnt - sb1[0].k >= 1) void'(sb1.pop_front());
    end
    exp_qv = (sb4.size() > 0) && (en_cnt - sb4[0].k == 3);
    chk("sb_qv4", 32'(qv4), 32'(exp_qv));
    if (exp_qv) chk("sb_q4", 32'(q4), 32'(sb4[0].d));
    chk("sb_occ4", 32'(occ4), 32'(sb4.size()));
    chk("popcnt4", 32'(occ4), 32'($countones(vt4)));
    exp_qv = (sb1.size() > 0);
    chk("sb_qv1", 32'(qv1), 32'(exp_qv));
    if (exp_qv) chk("sb_q1", 32'(q1), 32'(sb1[0].d));
    chk("sb_occ1", 32'(occ1), 32'(sb1.size()));
    chk("taps1_eq_q1", 32'(taps1), 32'(q1));
  endtask

  typedef struct {
    logic        r, e, c;
    logic [7:0]  d;
    logic        dv;
    logic [31:0] taps;
    logic [3:0]  vt;
    logic        qv;
    logic [2:0]  occ;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input logic [7:0] dd,
                     input logic dv, input logic [31:0] t, input logic [3:0] v,
                     input logic qv, input logic [2:0] o);
    vecs.push_back('{r, e, c, dd, dv, t, v, qv, o});
  endtask

  initial begin
    // reset with junk on the inputs
    add(1,0,0,8'hFF,1, 32'hA5A5A5A5, 4'h0,0,0);
    add(1,0,0,8'hFF,1, 32'hA5A5A5A5, 4'h0,0,0);
    // stream 01..05, then drain
    add(0,1,0,8'h01,1, 32'hA5A5A501, 4'h1,0,1);
    add(0,1,0,8'h02,1, 32'hA5A50102, 4'h3,0,2);
    add(0,1,0,8'h03,1, 32'hA5010203, 4'h7,0,3);
    add(0,1,0,8'h04,1, 32'h01020304, 4'hF,1,4);
    add(0,1,0,8'h05,1, 32'h02030405, 4'hF,1,4);
    add(0,1,0,8'h06,0, 32'h03040506, 4'hE,1,3);
    add(0,1,0,8'h07,0, 32'h04050607, 4'hC,1,2);
    add(0,1,0,8'h08,0, 32'h05060708, 4'h8,1,1);
    add(0,1,0,8'h09,0, 32'h06070809, 4'h0,0,0);
    // mixed valid 1,0,1,1,0
    add(0,1,0,8'h11,1, 32'h07080911, 4'h1,0,1);
    add(0,1,0,8'h12,0, 32'h08091112, 4'h2,0,1);
    add(0,1,0,8'h13,1, 32'h09111213, 4'h5,0,2);
    add(0,1,0,8'h14,1, 32'h11121314, 4'hB,1,3);
    add(0,1,0,8'h15,0, 32'h12131415, 4'h6,0,2);
    add(0,1,0,8'h00,0, 32'h13141500, 4'hC,1,2);
    add(0,1,0,8'h00,0, 32'h14150000, 4'h8,1,1);
    add(0,1,0,8'h00,0, 32'h15000000, 4'h0,0,0);
    // stall for 3 cycles mid-stream: latency 4+3
    add(0,1,0,8'h21,1, 32'h00000021, 4'h1,0,1);
    add(0,0,0,8'hFF,1, 32'h00000021, 4'h1,0,1);
    add(0,0,0,8'hEE,0, 32'h00000021, 4'h1,0,1);
    add(0,0,0,8'h33,1, 32'h00000021, 4'h1,0,1);
    add(0,1,0,8'h22,1, 32'h00002122, 4'h3,0,2);
    add(0,1,0,8'h23,1, 32'h00212223, 4'h7,0,3);
    add(0,1,0,8'h24,1, 32'h21222324, 4'hF,1,4);
    // flush a full pipe with en=1: 77 enters invalid
    add(0,1,1,8'h77,1, 32'h22232477, 4'h0,0,0);
    add(0,1,0,8'h00,0, 32'h23247700, 4'h0,0,0);
    add(0,1,0,8'h00,0, 32'h24770000, 4'h0,0,0);
    add(0,1,0,8'h00,0, 32'h77000000, 4'h0,0,0);
    // flush with en=0: data holds
    add(0,1,0,8'h31,1, 32'h00000031, 4'h1,0,1);
    add(0,0,1,8'h32,1, 32'h00000031, 4'h0,0,0);
    // reset mid-stream at occupancy 3
    add(0,1,0,8'h41,1, 32'h00003141, 4'h1,0,1);
    add(0,1,0,8'h42,1, 32'h00314142, 4'h3,0,2);
    add(0,1,0,8'h43,1, 32'h31414243, 4'h7,0,3);
    add(1,1,0,8'h44,1, 32'hA5A5A5A5, 4'h0,0,0);
    add(0,1,0,8'h51,1, 32'hA5A5A551, 4'h1,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].d, vecs[i].dv);
      chk($sformatf("taps4[%0d]", i), taps4, vecs[i].taps);
      chk($sformatf("vt4[%0d]", i), 32'(vt4), 32'(vecs[i].vt));
      chk($sformatf("qv4[%0d]", i), 32'(qv4), 32'(vecs[i].qv));
      chk($sformatf("q4[%0d]", i), 32'(q4), 32'(vecs[i].taps[31:24]));
      chk($sformatf("occ4[%0d]", i), 32'(occ4), 32'(vecs[i].occ));
    end

    // DEPTH=1: single enabled flop, latency of one edge
    step(1,0,0,8'hFF,1);
    chk("d1_rst_q", 32'(q1), 32'hA5);
    chk("d1_rst_qv", 32'(qv1), 32'h0);
    step(0,1,0,8'h01,1);
    chk("d1_lat_q", 32'(q1), 32'h01);
    chk("d1_lat_qv", 32'(qv1), 32'h1);
    chk("d1_lat_occ", 32'(occ1), 32'h1);
    step(0,1,0,8'h02,1);
    chk("d1_q2", 32'(q1), 32'h02);
    step(0,0,0,8'h03,0);
    chk("d1_hold_q", 32'(q1), 32'h02);
    chk("d1_hold_qv", 32'(qv1), 32'h1);
    step(0,1,1,8'h04,1);
    chk("d1_clr_q", 32'(q1), 32'h04);
    chk("d1_clr_qv", 32'(qv1), 32'h0);
    chk("d1_clr_occ", 32'(occ1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
